// File: rtl/sequenced_controller.sv
// Main control FSM: opcode decode, memory wait, halt drain,
// illegal-opcode tracking and a saturating issue counter.
module sequenced_controller #(
  parameter int MEM_MODE     = 0,
  parameter int MEM_WAIT     = 2,
  parameter int WAIT_TIMEOUT = 64,
  parameter int DRAIN_DEPTH  = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             Valid,
  input  logic             MemAck,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             Branch,
  output logic             JALSel,
  output logic             JALRSel,
  output logic [1:0]       RWSel,
  output logic             Halt,
  output logic             Stall,
  output logic             Halted,
  output logic             IllegalOp,
  output logic             IllegalSeen,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_HALT   = 7'b1110101;

  localparam logic [7:0] MW_LAST = 8'(MEM_WAIT - 1);
  localparam logic [7:0] TO_LAST = 8'(WAIT_TIMEOUT - 1);
  localparam logic [7:0] DR_LAST = 8'(DRAIN_DEPTH - 1);
  localparam bit MEM_STALL = (MEM_MODE != 0) || (MEM_WAIT != 0);

  typedef enum logic [1:0] {
    RUN, MEMWAIT, DRAIN, HALTED
  } state_e;

  state_e           state_q;
  logic [6:0]       op_q;
  logic [7:0]       cnt_q;
  logic             ill_seen_q;
  logic             tmo_q;
  logic [CNT_W-1:0] icnt_q;
  logic [CNT_W-1:0] icnt_d;
  logic [6:0]       dec_op;
  logic             legal;
  logic             issue;
  logic             ctl_en;
  logic             is_mem;

  assign legal = Opcode inside {OP_LOAD, OP_STORE, OP_R,
                                OP_I, OP_LUI, OP_BRANCH,
                                OP_JAL, OP_JALR, OP_AUIPC,
                                OP_HALT};

  // Opcode/Valid are only live in RUN; reset gates them off.
  assign issue     = !reset && state_q == RUN && Valid && legal;
  assign IllegalOp = !reset && state_q == RUN && Valid && !legal;
  assign ctl_en    = issue || (!reset && state_q == MEMWAIT);
  assign dec_op    = (state_q == MEMWAIT) ? op_q : Opcode;
  assign is_mem    = Opcode == OP_LOAD || Opcode == OP_STORE;

  assign Stall       = state_q != RUN;
  assign Halted      = state_q == HALTED;
  assign IllegalSeen = ill_seen_q;
  assign MemTimeout  = tmo_q;
  assign InstrCount  = icnt_q;

  assign icnt_d = (icnt_q == '1) ? icnt_q
                                 : icnt_q + CNT_W'(1);

  always_comb begin
    ALUOp    = 2'b00;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    Branch   = 1'b0;
    JALSel   = 1'b0;
    JALRSel  = 1'b0;
    RWSel    = 2'b00;
    Halt     = 1'b0;
    if (ctl_en) begin
      case (dec_op)
        OP_LOAD: begin
          ALUSrc   = 1'b1;
          MemRead  = 1'b1;
          MemToReg = 1'b1;
          RegWrite = 1'b1;
        end
        OP_STORE: begin
          ALUSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        OP_R: begin
          ALUOp    = 2'b10;
          RegWrite = 1'b1;
        end
        OP_I: begin
          ALUOp    = 2'b10;
          ALUSrc   = 1'b1;
          RegWrite = 1'b1;
        end
        OP_LUI: begin
          ALUOp    = 2'b11;
          ALUSrc   = 1'b1;
          RegWrite = 1'b1;
        end
        OP_BRANCH: begin
          ALUOp  = 2'b01;
          Branch = 1'b1;
        end
        OP_JAL: begin
          ALUOp    = 2'b11;
          RegWrite = 1'b1;
          JALSel   = 1'b1;
          RWSel    = 2'b01;
        end
        OP_JALR: begin
          ALUOp    = 2'b11;
          RegWrite = 1'b1;
          JALRSel  = 1'b1;
          RWSel    = 2'b01;
        end
        OP_AUIPC: begin
          RegWrite = 1'b1;
          RWSel    = 2'b11;
        end
        OP_HALT: Halt = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      op_q       <= '0;
      cnt_q      <= '0;
      ill_seen_q <= 1'b0;
      tmo_q      <= 1'b0;
      icnt_q     <= '0;
    end else begin
      if (IllegalOp) ill_seen_q <= 1'b1;
      case (state_q)
        RUN: begin
          if (issue) begin
            icnt_q <= icnt_d;
            cnt_q  <= '0;
            if (is_mem) begin
              op_q <= Opcode;
              if (MEM_STALL) state_q <= MEMWAIT;
            end else if (Opcode == OP_HALT) begin
              if (DRAIN_DEPTH == 0) state_q <= HALTED;
              else                  state_q <= DRAIN;
            end
          end
        end
        MEMWAIT: begin
          if (MEM_MODE == 0) begin
            if (cnt_q == MW_LAST) state_q <= RUN;
            else                  cnt_q   <= cnt_q + 8'd1;
          end else if (MemAck) begin
            state_q <= RUN;
          end else if (cnt_q == TO_LAST) begin
            tmo_q   <= 1'b1;
            state_q <= HALTED;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DRAIN: begin
          if (cnt_q == DR_LAST) state_q <= HALTED;
          else                  cnt_q   <= cnt_q + 8'd1;
        end
        HALTED: ;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenced_controller.sv
// Bench for sequenced_controller: three parameter sets share
// one stimulus stream, checked against a countdown-style model.
module tb_sequenced_controller;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] OPI    = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] HALT   = 7'b1110101;

  localparam int K_RUN = 0;
  localparam int K_MEM = 1;
  localparam int K_DRN = 2;
  localparam int K_HLT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       Valid;
  logic       MemAck;

  logic [1:0] aluop[3];
  logic [1:0] rwsel[3];
  logic alusrc[3], mrd[3], mwr[3], m2r[3], rwr[3];
  logic br[3], jal[3], jalr[3], hlt[3], stl[3];
  logic hltd[3], ill[3], ills[3], tmo[3];
  logic [31:0] ic_a, ic_b;
  logic [1:0]  ic_c;

  int total = 0;
  int bad   = 0;

  int mm[3] = '{0, 1, 0};
  int mw[3] = '{2, 2, 0};
  int wt[3] = '{64, 4, 64};
  int dd[3] = '{4, 0, 1};
  int cw[3] = '{32, 32, 2};

  int         kind[3];
  int         left[3];
  logic [6:0] lop[3];
  longint     cnt[3];
  bit         seen[3];
  bit         mto[3];

  always #5 clk = ~clk;

  sequenced_controller #(
    .MEM_MODE(0), .MEM_WAIT(2), .WAIT_TIMEOUT(64),
    .DRAIN_DEPTH(4), .CNT_W(32)
  ) u_a (
    .clk(clk), .reset(reset), .Opcode(Opcode),
    .Valid(Valid), .MemAck(MemAck),
    .ALUOp(aluop[0]), .ALUSrc(alusrc[0]),
    .MemRead(mrd[0]), .MemWrite(mwr[0]),
    .MemToReg(m2r[0]), .RegWrite(rwr[0]),
    .Branch(br[0]), .JALSel(jal[0]),
    .JALRSel(jalr[0]), .RWSel(rwsel[0]),
    .Halt(hlt[0]), .Stall(stl[0]), .Halted(hltd[0]),
    .IllegalOp(ill[0]), .IllegalSeen(ills[0]),
    .MemTimeout(tmo[0]), .InstrCount(ic_a)
  );

  sequenced_controller #(
    .MEM_MODE(1), .MEM_WAIT(2), .WAIT_TIMEOUT(4),
    .DRAIN_DEPTH(0), .CNT_W(32)
  ) u_b (
    .clk(clk), .reset(reset), .Opcode(Opcode),
    .Valid(Valid), .MemAck(MemAck),
    .ALUOp(aluop[1]), .ALUSrc(alusrc[1]),
    .MemRead(mrd[1]), .MemWrite(mwr[1]),
    .MemToReg(m2r[1]), .RegWrite(rwr[1]),
    .Branch(br[1]), .JALSel(jal[1]),
    .JALRSel(jalr[1]), .RWSel(rwsel[1]),
    .Halt(hlt[1]), .Stall(stl[1]), .Halted(hltd[1]),
    .IllegalOp(ill[1]), .IllegalSeen(ills[1]),
    .MemTimeout(tmo[1]), .InstrCount(ic_b)
  );

  sequenced_controller #(
    .MEM_MODE(0), .MEM_WAIT(0), .WAIT_TIMEOUT(64),
    .DRAIN_DEPTH(1), .CNT_W(2)
  ) u_c (
    .clk(clk), .reset(reset), .Opcode(Opcode),
    .Valid(Valid), .MemAck(MemAck),
    .ALUOp(aluop[2]), .ALUSrc(alusrc[2]),
    .MemRead(mrd[2]), .MemWrite(mwr[2]),
    .MemToReg(m2r[2]), .RegWrite(rwr[2]),
    .Branch(br[2]), .JALSel(jal[2]),
    .JALRSel(jalr[2]), .RWSel(rwsel[2]),
    .Halt(hlt[2]), .Stall(stl[2]), .Halted(hltd[2]),
    .IllegalOp(ill[2]), .IllegalSeen(ills[2]),
    .MemTimeout(tmo[2]), .InstrCount(ic_c)
  );

  // {legal, ALUOp, ALUSrc, MemRead, MemWrite, MemToReg,
  //  RegWrite, Branch, JALSel, JALRSel, RWSel, Halt}
  function automatic logic [13:0] tbl(input logic [6:0] op);
    case (op)
      LOAD:    return 14'b1_00_11011000_00_0;
      STORE:   return 14'b1_00_10100000_00_0;
      OPR:     return 14'b1_10_00001000_00_0;
      OPI:     return 14'b1_10_10001000_00_0;
      LUI:     return 14'b1_11_10001000_00_0;
      BRANCH:  return 14'b1_01_00000100_00_0;
      JAL:     return 14'b1_11_00001010_01_0;
      JALR:    return 14'b1_11_00001001_01_0;
      AUIPC:   return 14'b1_00_00001000_11_0;
      HALT:    return 14'b1_00_00000000_00_1;
      default: return 14'b0;
    endcase
  endfunction

  function automatic logic [17:0] obsv(input int i);
    return {aluop[i], alusrc[i], mrd[i], mwr[i], m2r[i],
            rwr[i], br[i], jal[i], jalr[i], rwsel[i],
            hlt[i], stl[i], hltd[i], ill[i], ills[i],
            tmo[i]};
  endfunction

  function automatic logic [31:0] obsc(input int i);
    if (i == 0) return ic_a;
    if (i == 1) return ic_b;
    return {30'b0, ic_c};
  endfunction

  function automatic logic [17:0] expv(input int i);
    logic [13:0] t;
    logic [12:0] ctl;
    logic        il;
    ctl = '0;
    il  = 1'b0;
    if (reset) return '0;
    if (kind[i] == K_RUN) begin
      t = tbl(Opcode);
      if (Valid && t[13]) ctl = t[12:0];
      il = Valid && !t[13];
    end else if (kind[i] == K_MEM) begin
      t   = tbl(lop[i]);
      ctl = t[12:0];
    end
    return {ctl, kind[i] != K_RUN, kind[i] == K_HLT,
            il, seen[i], mto[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      kind[i] = K_RUN;
      left[i] = 0;
      lop[i]  = '0;
      cnt[i]  = 0;
      seen[i] = 1'b0;
      mto[i]  = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [13:0] t;
    longint      top;
    for (int i = 0; i < 3; i++) begin
      t   = tbl(Opcode);
      top = (longint'(1) << cw[i]) - 1;
      case (kind[i])
        K_RUN: begin
          if (Valid && !t[13]) seen[i] = 1'b1;
          if (Valid && t[13]) begin
            if (cnt[i] < top) cnt[i]++;
            if (Opcode == LOAD || Opcode == STORE) begin
              lop[i] = Opcode;
              if (mm[i] == 1) begin
                kind[i] = K_MEM;
                left[i] = wt[i];
              end else if (mw[i] > 0) begin
                kind[i] = K_MEM;
                left[i] = mw[i];
              end
            end else if (Opcode == HALT) begin
              if (dd[i] > 0) begin
                kind[i] = K_DRN;
                left[i] = dd[i];
              end else begin
                kind[i] = K_HLT;
              end
            end
          end
        end
        K_MEM: begin
          if (mm[i] == 1 && MemAck) begin
            kind[i] = K_RUN;
          end else begin
            left[i]--;
            if (left[i] == 0) begin
              if (mm[i] == 1) begin
                kind[i] = K_HLT;
                mto[i]  = 1'b1;
              end else begin
                kind[i] = K_RUN;
              end
            end
          end
        end
        K_DRN: begin
          left[i]--;
          if (left[i] == 0) kind[i] = K_HLT;
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d.outputs", i),
          32'(obsv(i)), 32'(expv(i)));
      chk($sformatf("dut%0d.count", i),
          obsc(i), cnt[i][31:0]);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op,
                       input logic ack);
    Valid  = v;
    Opcode = op;
    MemAck = ack;
    @(negedge clk);
    check_model();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [6:0] pick();
    int r;
    r = $urandom_range(0, 49);
    if (r == 0) return HALT;
    if (r < 6) return 7'($urandom);
    case ($urandom_range(0, 8))
      0: return LOAD;
      1: return STORE;
      2: return OPR;
      3: return OPI;
      4: return LUI;
      5: return BRANCH;
      6: return JAL;
      7: return JALR;
      default: return AUIPC;
    endcase
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    Valid  = 1'b1;
    Opcode = pick();
    MemAck = 1'b1;
    model_reset();
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [17:0] v;
    int e29[5] = '{1, 2, 3, 3, 3};
    reset  = 1'b1;
    Valid  = 1'b1;
    Opcode = LOAD;
    MemAck = 1'b0;
    model_reset();
    @(negedge clk);
    v = obsv(0);
    chk("reset.outputs", 32'(v), 32'd0);
    chk("reset.count", ic_a, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    do_reset();
    drive(1'b1, LOAD, 1'b0);
    chk("ld.memread.c0", 32'(mrd[0]), 32'd1);
    chk("ld.stall.c0", 32'(stl[0]), 32'd0);
    adv();
    drive(1'b0, OPR, 1'b0);
    chk("ld.memread.c1", 32'(mrd[0]), 32'd1);
    chk("ld.stall.c1", 32'(stl[0]), 32'd1);
    chk("ld.count", ic_a, 32'd1);
    adv();
    drive(1'b0, OPR, 1'b0);
    chk("ld.memread.c2", 32'(mrd[0]), 32'd1);
    chk("ld.stall.c2", 32'(stl[0]), 32'd1);
    adv();
    drive(1'b0, OPR, 1'b0);
    chk("ld.stall.c3", 32'(stl[0]), 32'd0);
    adv();

    do_reset();
    drive(1'b1, STORE, 1'b0);
    chk("st.memwrite.c0", 32'(mwr[1]), 32'd1);
    adv();
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 7'd0, c == 3);
      chk("st.stall", 32'(stl[1]), 32'd1);
      chk("st.memwrite", 32'(mwr[1]), 32'd1);
      adv();
    end
    drive(1'b0, 7'd0, 1'b0);
    chk("st.stall.c4", 32'(stl[1]), 32'd0);
    adv();

    do_reset();
    drive(1'b1, LOAD, 1'b0);
    adv();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 7'd0, 1'b0);
      chk("tmo.stall", 32'(stl[1]), 32'd1);
      chk("tmo.halted.early", 32'(hltd[1]), 32'd0);
      adv();
    end
    drive(1'b0, 7'd0, 1'b0);
    chk("tmo.halted", 32'(hltd[1]), 32'd1);
    chk("tmo.flag", 32'(tmo[1]), 32'd1);
    adv();

    do_reset();
    drive(1'b1, HALT, 1'b0);
    chk("halt.pulse", 32'(hlt[0]), 32'd1);
    adv();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 7'd0, 1'b0);
      chk("drain.stall", 32'(stl[0]), 32'd1);
      chk("drain.halted", 32'(hltd[0]), 32'd0);
      adv();
    end
    drive(1'b1, LOAD, 1'b0);
    chk("halted.flag", 32'(hltd[0]), 32'd1);
    chk("halted.memread", 32'(mrd[0]), 32'd0);
    adv();
    drive(1'b0, 7'd0, 1'b0);
    chk("halted.count", ic_a, 32'd1);
    adv();

    do_reset();
    drive(1'b1, 7'h7F, 1'b0);
    v = obsv(0);
    chk("ill.flag", 32'(ill[0]), 32'd1);
    chk("ill.controls", 32'(v[17:5]), 32'd0);
    adv();
    drive(1'b0, 7'd0, 1'b0);
    chk("ill.seen", 32'(ills[0]), 32'd1);
    chk("ill.count", ic_a, 32'd0);
    adv();
    do_reset();
    drive(1'b0, JAL, 1'b0);
    v = obsv(0);
    chk("novalid.outputs", 32'(v), 32'd0);
    adv();

    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, OPR, 1'b0);
      adv();
      chk("sat.count", 32'(ic_c), 32'(e29[k]));
    end
    do_reset();
    drive(1'b1, LOAD, 1'b0);
    adv();
    drive(1'b0, 7'd0, 1'b0);
    chk("abort.stall.before", 32'(stl[0]), 32'd1);
    do_reset();
    drive(1'b0, 7'd0, 1'b0);
    chk("abort.stall.after", 32'(stl[0]), 32'd0);
    adv();

    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 5) != 0, pick(),
              $urandom_range(0, 3) == 0);
        adv();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
